// File: rtl/dfx_packet_encap.sv
// DFX packet encapsulator: builds one header flit plus NUMBER_PACKET payload flits
// from the local DFX source and writes them into router input port 0 FIFO.
module dfx_packet_encap #(
    parameter int AURORA_DATA_WIDTH = 64,
    parameter int ADDR_WIDTH        = 10,
    parameter int NUMBER_PACKET     = 19,
    parameter int CNT_WIDTH         = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         encap_start,
    input  logic [ADDR_WIDTH-1:0]        router_dst_addr_send,
    input  logic [8:0]                   header_pkt_send,
    output logic                         ready_encap_dfx,
    input  logic [AURORA_DATA_WIDTH-1:0] src_data,
    input  logic                         src_valid,
    output logic                         src_ready,
    input  logic                         full_input_port_0,
    output logic                         wr_input_port_0,
    output logic [AURORA_DATA_WIDTH-1:0] data_input_port_0,
    output logic                         encap_busy,
    output logic                         encap_done,
    output logic [CNT_WIDTH-1:0]         pkt_sent_cnt
);

    localparam int FLIT_W = (NUMBER_PACKET > 1) ? $clog2(NUMBER_PACKET) : 1;
    localparam logic [FLIT_W-1:0] LAST_FLIT = FLIT_W'(NUMBER_PACKET - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t                  state_r;
    state_t                  next_state_s;
    logic [FLIT_W-1:0]       flit_cnt_r;
    logic [ADDR_WIDTH-1:0]   dst_r;
    logic [8:0]              hdr_r;
    logic [CNT_WIDTH-1:0]    pkt_cnt_r;
    logic                    wr_s;
    logic [AURORA_DATA_WIDTH-1:0] data_s;
    logic                    src_ready_s;
    logic                    flit_adv_s;

    // Header flit: type 2'b01, header field, destination address, upper bits zero.
    function automatic logic [AURORA_DATA_WIDTH-1:0] build_header(
        input logic [ADDR_WIDTH-1:0] dst,
        input logic [8:0]            hdr
    );
        logic [AURORA_DATA_WIDTH-1:0] flit;
        flit                   = '0;
        flit[1:0]              = 2'b01;
        flit[10:2]             = hdr;
        flit[ADDR_WIDTH+10:11] = dst;
        return flit;
    endfunction

    // Next-state decode and FIFO/source handshake, all gated by FIFO full.
    always_comb begin
        next_state_s = state_r;
        wr_s         = 1'b0;
        data_s       = '0;
        src_ready_s  = 1'b0;
        flit_adv_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (encap_start) begin
                    next_state_s = ST_HDR;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (!full_input_port_0) begin
                    wr_s         = 1'b1;
                    data_s       = build_header(dst_r, hdr_r);
                    next_state_s = ST_PAYLOAD;
                end else begin
                    next_state_s = ST_HDR;
                end
            end
            ST_PAYLOAD: begin
                src_ready_s = !full_input_port_0;
                if (src_valid && !full_input_port_0) begin
                    wr_s       = 1'b1;
                    data_s     = src_data;
                    flit_adv_s = 1'b1;
                    if (flit_cnt_r == LAST_FLIT) begin
                        next_state_s = ST_DONE;
                    end else begin
                        next_state_s = ST_PAYLOAD;
                    end
                end else begin
                    next_state_s = ST_PAYLOAD;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register, request capture, flit and completed-packet counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            flit_cnt_r <= '0;
            dst_r      <= '0;
            hdr_r      <= '0;
            pkt_cnt_r  <= '0;
        end else begin
            state_r <= next_state_s;
            if ((state_r == ST_IDLE) && encap_start) begin
                dst_r      <= router_dst_addr_send;
                hdr_r      <= header_pkt_send;
                flit_cnt_r <= '0;
            end else if (flit_adv_s) begin
                flit_cnt_r <= flit_cnt_r + FLIT_W'(1);
            end
            if (state_r == ST_DONE) begin
                pkt_cnt_r <= pkt_cnt_r + CNT_WIDTH'(1);
            end
        end
    end

    assign ready_encap_dfx   = (state_r == ST_IDLE);
    assign encap_busy        = (state_r != ST_IDLE);
    assign encap_done        = (state_r == ST_DONE);
    assign pkt_sent_cnt      = pkt_cnt_r;
    assign wr_input_port_0   = wr_s;
    assign data_input_port_0 = data_s;
    assign src_ready         = src_ready_s;

endmodule

// File: tb/tb_dfx_packet_encap.sv
// Directed self-checking bench for dfx_packet_encap: inputs driven 1ns after posedge,
// outputs sampled on negedge; FIFO writes and source consumption collected per cycle.
module tb_dfx_packet_encap;

    localparam int DW = 64;
    localparam int AW = 10;
    localparam int NP = 19;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          encap_start;
    logic [AW-1:0] dst;
    logic [8:0]    hdr;
    logic          ready;
    logic [DW-1:0] src_data;
    logic          src_valid;
    logic          src_ready;
    logic          full;
    logic          wr;
    logic [DW-1:0] wdata;
    logic          busy;
    logic          done;
    logic [CW-1:0] cnt;

    int checks   = 0;
    int errors   = 0;
    int src_idx  = 0;
    int done_cnt = 0;
    logic [DW-1:0] wr_q[$];

    dfx_packet_encap #(
        .AURORA_DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUMBER_PACKET(NP), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .encap_start(encap_start),
        .router_dst_addr_send(dst), .header_pkt_send(hdr), .ready_encap_dfx(ready),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .full_input_port_0(full), .wr_input_port_0(wr), .data_input_port_0(wdata),
        .encap_busy(busy), .encap_done(done), .pkt_sent_cnt(cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mkword(input int idx);
        return {32'hCAFE_0000 + 32'(idx), 32'h1234_5678 ^ 32'(idx)};
    endfunction

    // One clock cycle: drive inputs, then sample outputs mid-cycle.
    task automatic step(input logic r, input logic st, input logic v, input logic f);
        @(posedge clk);
        #1;
        rst = r; encap_start = st; src_valid = v; full = f;
        src_data = mkword(src_idx);
        @(negedge clk);
        checks++;
        if ((wr && full) || (src_ready && (full || !busy)) || (!wr && wdata !== 64'd0)) begin
            errors++;
            $display("FAIL invariant: wr=%b full=%b src_ready=%b busy=%b data=%h, required no write/ready while full or idle and zero data without write",
                     wr, full, src_ready, busy, wdata);
        end
        if (wr) wr_q.push_back(wdata);
        if (src_valid && src_ready) src_idx++;
        if (done) done_cnt++;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({ready, busy, done, src_ready, wr} !== 5'b10000) begin
            errors++; $display("FAIL reset_flags: got %b exp 10000", {ready, busy, done, src_ready, wr});
        end
        checks++;
        if (cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d exp 0", cnt); end
        checks++;
        if (wdata !== 64'd0) begin errors++; $display("FAIL reset_data: got %h exp 0", wdata); end
        wr_q.delete();
    endtask

    task automatic test_basic();
        int base;
        int d0;
        wr_q.delete(); base = src_idx; d0 = done_cnt;
        dst = 10'h00A; hdr = 9'h0AB;
        step(1'b0, 1'b1, 1'b1, 1'b0);
        for (int c = 1; c <= 21; c++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0);
            if (c == 1) begin
                checks++;
                if (wr !== 1'b1 || wdata !== 64'h52AD) begin
                    errors++; $display("FAIL t1_hdr_latency: wr=%b data=%h exp wr=1 data=52ad", wr, wdata);
                end
            end
        end
        checks++;
        if (done !== 1'b1 || cnt !== 8'd0 || wr_q.size() != 20) begin
            errors++; $display("FAIL t1_done_cycle: done=%b cnt=%0d writes=%0d exp 1/0/20", done, cnt, wr_q.size());
        end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (done !== 1'b0 || ready !== 1'b1 || cnt !== 8'd1 || done_cnt - d0 != 1) begin
            errors++; $display("FAIL t1_after: done=%b ready=%b cnt=%0d pulses=%0d exp 0/1/1/1", done, ready, cnt, done_cnt - d0);
        end
        for (int k = 1; k < 20; k++) begin
            checks++;
            if (wr_q[k] !== mkword(base + k - 1)) begin
                errors++; $display("FAIL t1_payload[%0d]: got %h exp %h", k, wr_q[k], mkword(base + k - 1));
            end
        end
    endtask

    task automatic test_backpressure();
        int base;
        int done_c;
        logic f;
        wr_q.delete(); base = src_idx; done_c = 0;
        dst = 10'h155; hdr = 9'h0F0;
        step(1'b0, 1'b1, 1'b1, 1'b0);
        for (int c = 1; c <= 60; c++) begin
            f = ((c >= 1) && (c <= 3)) || (c == 9) || (c == 10);
            step(1'b0, 1'b0, 1'b1, f);
            if (done) begin done_c = c; break; end
        end
        checks++;
        if (done_c != 26) begin errors++; $display("FAIL t2_done_cycle: got %0d exp 26", done_c); end
        checks++;
        if (wr_q.size() != 20 || wr_q[0] !== 64'hA_ABC1) begin
            errors++; $display("FAIL t2_hdr: writes=%0d hdr=%h exp 20/aabc1", wr_q.size(), wr_q[0]);
        end
        for (int k = 1; k < 20; k++) begin
            checks++;
            if (wr_q[k] !== mkword(base + k - 1)) begin
                errors++; $display("FAIL t2_payload[%0d]: got %h exp %h", k, wr_q[k], mkword(base + k - 1));
            end
        end
    endtask

    task automatic test_valid_toggle();
        int base;
        int done_c;
        wr_q.delete(); base = src_idx; done_c = 0;
        dst = 10'h001; hdr = 9'h000;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int c = 1; c <= 80; c++) begin
            step(1'b0, 1'b0, (c % 2 == 0), 1'b0);
            if (done) begin done_c = c; break; end
        end
        checks++;
        if (done_c != 39 || wr_q.size() != 20) begin
            errors++; $display("FAIL t3_timing: done_cycle=%0d writes=%0d exp 39/20", done_c, wr_q.size());
        end
        checks++;
        if (wr_q[0] !== 64'h801) begin errors++; $display("FAIL t3_hdr: got %h exp 801", wr_q[0]); end
        for (int k = 1; k < 20; k++) begin
            checks++;
            if (wr_q[k] !== mkword(base + k - 1)) begin
                errors++; $display("FAIL t3_payload[%0d]: got %h exp %h", k, wr_q[k], mkword(base + k - 1));
            end
        end
    endtask

    task automatic test_start_ignored();
        int base;
        int d0;
        int done_c;
        wr_q.delete(); base = src_idx; d0 = done_cnt; done_c = 0;
        dst = 10'h00B; hdr = 9'h011;
        step(1'b0, 1'b1, 1'b1, 1'b0);
        for (int c = 1; c <= 40; c++) begin
            if (c == 8) begin dst = 10'h3FF; hdr = 9'h1FF; end
            step(1'b0, (c == 8), 1'b1, 1'b0);
            if (done) begin done_c = c; break; end
        end
        for (int c = 0; c < 5; c++) step(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (done_c != 21 || wr_q.size() != 20 || done_cnt - d0 != 1 || ready !== 1'b1) begin
            errors++; $display("FAIL t4_ignored: done_cycle=%0d writes=%0d pulses=%0d ready=%b exp 21/20/1/1",
                               done_c, wr_q.size(), done_cnt - d0, ready);
        end
        checks++;
        if (wr_q[0] !== 64'h5845) begin errors++; $display("FAIL t4_hdr: got %h exp 5845", wr_q[0]); end
        for (int k = 1; k < 20; k++) begin
            checks++;
            if (wr_q[k] !== mkword(base + k - 1)) begin
                errors++; $display("FAIL t4_payload[%0d]: got %h exp %h", k, wr_q[k], mkword(base + k - 1));
            end
        end
    endtask

    task automatic test_reset_mid();
        int base;
        int d0;
        wr_q.delete(); d0 = done_cnt;
        dst = 10'h0C0; hdr = 9'h022;
        step(1'b0, 1'b1, 1'b1, 1'b0);
        for (int c = 1; c <= 8; c++) step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (ready !== 1'b1 || busy !== 1'b0 || wr !== 1'b0 || cnt !== 8'd0) begin
            errors++; $display("FAIL t5_after_rst: ready=%b busy=%b wr=%b cnt=%0d exp 1/0/0/0", ready, busy, wr, cnt);
        end
        checks++;
        if (wr_q.size() != 8 || done_cnt != d0 || wr_q[0] !== 64'h6_0089) begin
            errors++; $display("FAIL t5_partial: writes=%0d pulses=%0d hdr=%h exp 8/0/60089", wr_q.size(), done_cnt - d0, wr_q[0]);
        end
        wr_q.delete(); base = src_idx;
        step(1'b0, 1'b1, 1'b1, 1'b0);
        for (int c = 1; c <= 22; c++) step(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (wr_q.size() != 20 || wr_q[0] !== 64'h6_0089 || cnt !== 8'd1 || ready !== 1'b1) begin
            errors++; $display("FAIL t5_fresh: writes=%0d hdr=%h cnt=%0d ready=%b exp 20/60089/1/1", wr_q.size(), wr_q[0], cnt, ready);
        end
        for (int k = 1; k < 20; k++) begin
            checks++;
            if (wr_q[k] !== mkword(base + k - 1)) begin
                errors++; $display("FAIL t5_payload[%0d]: got %h exp %h", k, wr_q[k], mkword(base + k - 1));
            end
        end
    endtask

    task automatic test_back_to_back();
        int base;
        int d0;
        int bad;
        int p_idx;
        logic seen_ff;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        wr_q.delete(); base = src_idx; d0 = done_cnt; seen_ff = 1'b0; bad = 0;
        dst = 10'h3FF; hdr = 9'h1FF;
        for (int c = 0; c < 256 * 22 + 100; c++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0);
            if (cnt == 8'hFF) seen_ff = 1'b1;
            if (done_cnt - d0 == 256) break;
        end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (done_cnt - d0 != 256 || !seen_ff || cnt !== 8'd0) begin
            errors++; $display("FAIL t6_wrap: pulses=%0d seen_255=%b cnt=%0d exp 256/1/0", done_cnt - d0, seen_ff, cnt);
        end
        checks++;
        if (wr_q.size() < 256 * 20) begin
            errors++; $display("FAIL t6_writes: got %0d exp at least %0d", wr_q.size(), 256 * 20);
        end
        for (int p = 0; p < 256; p++) begin
            if (wr_q[p * 20] !== 64'h1F_FFFD) bad++;
            for (int k = 1; k < 20; k++) begin
                p_idx = p * 20 + k;
                if (wr_q[p_idx] !== mkword(base + p * NP + k - 1)) bad++;
            end
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL t6_data: bad flits %0d exp 0", bad); end
    endtask

    initial begin
        rst = 1'b1; encap_start = 1'b0; dst = '0; hdr = '0;
        src_valid = 1'b0; full = 1'b0; src_data = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_valid_toggle();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
